// File: rtl/sat_accumulator_pkg.sv
// Purpose : shared FSM encoding, saturation rails and clamp helper for sat_accumulator.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package sat_accumulator_pkg;

  // Frame FSM: ACC collects samples, HOLD presents one result to the consumer.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [7:0] SAT_MAX = 8'h7F;
  localparam logic [7:0] SAT_MIN = 8'h80;

  // On signed overflow both operands share a sign, so the sample's sign
  // alone tells which rail was crossed.
  function automatic logic [7:0] sat_select(input logic       ovf,
                                            input logic       sample_sign,
                                            input logic [7:0] raw_sum);
    logic [7:0] res;
    res = raw_sum;
    if (ovf) begin
      res = sample_sign ? SAT_MIN : SAT_MAX;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_accumulator_adder.sv
// Purpose : 8-bit two's-complement ripple-carry adder, carry-in 0, with signed overflow.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of a and b.
//
// Ports:
//   a, b : 8-bit operands (accumulator and incoming sample)
//   sum  : a + b modulo 256
//   ovf  : signed overflow = carry into MSB XOR carry out of MSB
module sat_accumulator_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       ovf
);

  logic carry;
  logic carry_into_msb;

  // Carry is rippled through a blocking variable so the chain is a plain
  // sequence of full adders rather than a self-referencing vector.
  always_comb begin
    sum            = '0;
    carry          = 1'b0;
    carry_into_msb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        carry_into_msb = carry;
      end
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    ovf = carry_into_msb ^ carry;
  end

endmodule

// File: rtl/sat_accumulator.sv
// Purpose : sums frames of COUNT signed 8-bit samples with saturation and a sticky sat flag.
// Latency : out_valid rises the cycle after the edge accepting the COUNT-th sample.
// Backpressure: HOLD state freezes the result and deasserts in_ready until out_ready.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst_n     : synchronous active-low reset, highest priority
//   in_valid  : in_data carries a sample
//   in_ready  : block accepts a sample this cycle (state decode only)
//   in_data   : signed 8-bit sample
//   out_valid : out_data/out_sat carry a frame result (state decode only)
//   out_ready : consumer takes the result this cycle
//   out_data  : signed saturated frame sum
//   out_sat   : a saturation event happened somewhere in the frame
module sat_accumulator
  import sat_accumulator_pkg::*;
#(
  parameter int unsigned COUNT = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  localparam logic [CW-1:0] LAST_IDX = CW'(COUNT - 1);

  state_e          state_q, state_d;
  logic [7:0]      acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sat_flag_q, sat_flag_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sat_q, out_sat_d;

  logic [7:0]      add_sum;
  logic            add_ovf;
  logic [7:0]      sat_sum;
  logic            accept;
  logic            release_res;

  sat_accumulator_adder u_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Clamped value; later samples continue from it, so the rail is not sticky.
  assign sat_sum = sat_select(add_ovf, in_data[7], add_sum);

  // Handshake outputs come straight from the state register so that neither
  // in_valid nor out_ready has a combinational path to the other side.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  assign accept      = in_valid && in_ready;
  assign release_res = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sat_flag_d = sat_flag_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;

    unique case (state_q)
      ACC: begin
        if (accept) begin
          acc_d      = sat_sum;
          sat_flag_d = sat_flag_q | add_ovf;
          cnt_d      = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            // Result register captures this accept's contribution directly.
            state_d    = HOLD;
            out_data_d = sat_sum;
            out_sat_d  = sat_flag_q | add_ovf;
          end
        end
      end
      HOLD: begin
        // Samples are ignored here; the clear happens on the handshake edge so
        // the next frame starts from zero the cycle in_ready returns.
        if (release_res) begin
          state_d    = ACC;
          acc_d      = '0;
          cnt_d      = '0;
          sat_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_flag_q <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sat_flag_q <= sat_flag_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// Purpose : self-checking bench for sat_accumulator (COUNT=4) with a frame-level model.
// Latency : model expects out_valid the cycle after the COUNT-th accept.
// Backpressure: exercises out_ready=0 stalls with in_valid held high.
module tb_sat_accumulator;

  localparam int COUNT = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int n_checks = 0;
  int n_fail   = 0;

  sat_accumulator #(.COUNT(COUNT), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: integer running sum clamped to [-128,127].
  bit         m_hold = 0;
  int         m_acc  = 0;
  int         m_cnt  = 0;
  bit         m_sat  = 0;
  logic [7:0] m_out  = 8'h00;
  bit         m_osat = 0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    int s;
    if (!rst_n) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0; m_out = 8'h00; m_osat = 0;
      chk_en = 1;
    end else if (!m_hold) begin
      if (in_valid) begin
        s = m_acc + int'($signed(in_data));
        if (s > 127) begin
          s = 127; m_sat = 1;
        end else if (s < -128) begin
          s = -128; m_sat = 1;
        end
        m_acc = s;
        m_cnt++;
        if (m_cnt == COUNT) begin
          m_hold = 1;
          m_out  = 8'(s);
          m_osat = m_sat;
        end
      end
    end else if (out_ready) begin
      m_hold = 0; m_acc = 0; m_cnt = 0; m_sat = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(!m_hold));
      check("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold) begin
        check("out_data", 32'(out_data), 32'(m_out));
        check("out_sat", 32'(out_sat), 32'(m_osat));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("send_timeout", 32'(guard < 50), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input int gap);
    send(a); repeat (gap) step();
    send(b); repeat (gap) step();
    send(c); repeat (gap) step();
    send(d);
  endtask

  // Called right after the 4th accept edge: result must already be presented.
  task automatic expect_result(input string name, input logic [7:0] d, input logic s);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_data"}, 32'(out_data), 32'(d));
    check({name, "_sat"}, 32'(out_sat), 32'(s));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Basic frame, back-to-back.
    send4(8'h01, 8'h02, 8'h03, 8'h04, 0);
    expect_result("basic", 8'h0A, 1'b0);
    step();
    check("basic_one_cycle", 32'(out_valid), 32'd0);
    check("basic_ready_back", 32'(in_ready), 32'd1);

    // Positive clamp.
    send4(8'h7F, 8'h01, 8'h00, 8'h00, 0);
    expect_result("posclamp", 8'h7F, 1'b1);
    step();

    // Negative clamp then recovery through 8'hFF to 8'h00.
    send4(8'h80, 8'hFF, 8'h7F, 8'h01, 0);
    expect_result("negclamp", 8'h00, 1'b1);
    step();

    // Backpressure with in_valid held high during the stall.
    out_ready = 1'b0;
    send4(8'h01, 8'h01, 8'h01, 8'h01, 0);
    expect_result("bp", 8'h04, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_data", 32'(out_data), 32'h04);
      check("bp_hold_sat", 32'(out_sat), 32'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send4(8'h01, 8'h02, 8'h03, 8'h04, 0);
    expect_result("bp_next", 8'h0A, 1'b0);
    step();

    // Reset mid-frame discards the partial sum.
    send(8'h10);
    send(8'h20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send4(8'h01, 8'h01, 8'h01, 8'h01, 0);
    expect_result("midrst", 8'h04, 1'b0);
    step();

    // Input gaps stall the frame; latency after the last accept is unchanged.
    send4(8'h01, 8'h02, 8'h03, 8'h04, 3);
    expect_result("gaps", 8'h0A, 1'b0);
    step();

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    send4(8'h05, 8'h05, 8'h05, 8'h05, 0);
    expect_result("holdrst", 8'h14, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("holdrst_valid", 32'(out_valid), 32'd0);
    check("holdrst_data", 32'(out_data), 32'h00);
    out_ready = 1'b1;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
